// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter: access sizes, FSM states, IO addresses.
package mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] IO_ADDR_UART = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_CLK  = 32'h0003_0004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR      = 2'd2,
    ST_IO_WAIT = 2'd3
  } state_e;

  // Bytes moved by one access; the illegal encoding 2'b11 behaves as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// One-hot grant picker: first requester at or after the pointer wins.
// With MEM_ARBITER_FIXED_PRIO_EN defined the search always starts at
// channel 0 (lowest index wins) and the pointer is ignored.
module mem_arbiter_rr_picker #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [PTR_W-1:0]  gnt_idx_o
);

  logic [PTR_W-1:0] start;
  logic [PTR_W-1:0] cand;
  logic             found;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign start      = '0;
`else
  assign start      = ptr_i;
`endif

  // Rotating scan from the start channel; the first hit is granted.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = PTR_W'((int'(start) + k) % NUM_CH);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: serialises 1/2/4-byte requests onto a
// byte-wide RAM/UART bus, little-endian, with round-robin arbitration.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         NUM_CH = 2,
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic [NUM_CH-1:0]              req_valid,
  input  logic [NUM_CH-1:0]              req_wr,
  input  logic [NUM_CH-1:0][1:0]         req_size,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_CH-1:0][31:0]        req_wdata,
  output logic [NUM_CH-1:0]              resp_done,
  output logic [31:0]                    resp_rdata,
  input  logic [7:0]                     mem_din,
  output logic [7:0]                     mem_dout,
  output logic [ADDR_W-1:0]              mem_a,
  output logic                           mem_wr,
  input  logic                           io_buffer_full
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [PTR_W-1:0]       ch_q, ch_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [3:0][7:0]        wdata_q, wdata_d;
  logic [2:0]             nb_q, nb_d;
  logic [2:0]             idx_q, idx_d;
  logic [3:0][7:0]        rbuf_q, rbuf_d;
  logic [NUM_CH-1:0]      done_q, done_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [ADDR_W-1:0]      mem_a_q, mem_a_d;
  logic [7:0]             dout_q, dout_d;
  logic                   wr_q, wr_d;
  logic                   rdy_prev_q;

  logic [NUM_CH-1:0]      gnt;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W-1:0]       rr_nxt;
  logic                   is_io;
  logic [2:0]             idx_nxt;

  mem_arbiter_rr_picker #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign rr_nxt  = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign is_io   = (req_addr[gnt_idx][17:16] == IO_HI);
  assign idx_nxt = idx_q + 3'd1;

  // Next-state and bus-output decode for the IDLE/RD/WR/IO_WAIT machine.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nb_d    = nb_q;
    idx_d   = idx_q;
    rbuf_d  = rbuf_q;
    done_d  = '0;
    rdata_d = rdata_q;
    mem_a_d = mem_a_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        // A flush on this edge suppresses any new grant.
        if (|gnt && !flush_in) begin
          ch_d    = gnt_idx;
          rr_d    = rr_nxt;
          addr_d  = req_addr[gnt_idx];
          wdata_d = req_wdata[gnt_idx];
          nb_d    = size_to_bytes(req_size[gnt_idx]);
          idx_d   = '0;
          rbuf_d  = '0;
          mem_a_d = req_addr[gnt_idx];
          dout_d  = req_wdata[gnt_idx][7:0];
          if (!req_wr[gnt_idx]) begin
            state_d = ST_RD;
            wr_d    = 1'b0;
          end else if (is_io && io_buffer_full) begin
            state_d = ST_IO_WAIT;
            wr_d    = 1'b0;
          end else begin
            state_d = ST_WR;
            wr_d    = 1'b1;
          end
        end
      end
      ST_IO_WAIT: begin
        if (!io_buffer_full) begin
          state_d = ST_WR;
          wr_d    = 1'b1;
          idx_d   = '0;
          mem_a_d = addr_q;
          dout_d  = wdata_q[0];
        end
      end
      ST_WR: begin
        // The byte on the bus is written at this edge; advance or finish.
        if (idx_q == nb_q - 3'd1) begin
          wr_d         = 1'b0;
          done_d[ch_q] = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          idx_d   = idx_nxt;
          mem_a_d = addr_q + ADDR_W'(idx_nxt);
          dout_d  = wdata_q[idx_nxt[1:0]];
        end
      end
      ST_RD: begin
        if (flush_in) begin
          state_d = ST_IDLE;
        end else if (idx_q == nb_q) begin
          done_d[ch_q] = 1'b1;
          rdata_d      = rbuf_q;
          state_d      = ST_IDLE;
        end else if (!rdy_prev_q) begin
          // First edge after a pause: the held byte may be stale, fetch it again.
          mem_a_d = addr_q + ADDR_W'(idx_q);
        end else begin
          rbuf_d[idx_q[1:0]] = mem_din;
          idx_d              = idx_nxt;
          if (idx_nxt != nb_q) mem_a_d = addr_q + ADDR_W'(idx_nxt);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      nb_q    <= 3'd1;
      idx_q   <= '0;
      rbuf_q  <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      mem_a_q <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      nb_q    <= nb_d;
      idx_q   <= idx_d;
      rbuf_q  <= rbuf_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      mem_a_q <= mem_a_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
    end
  end

  // Remembers whether the previous edge was a paused one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rdy_prev_q <= 1'b1;
    else        rdy_prev_q <= rdy_in;
  end

  assign resp_done  = done_q;
  assign resp_rdata = rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = dout_q;
  // Gated so a byte held across a pause is written exactly once.
  assign mem_wr     = wr_q & rdy_in;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised multi-channel memory controller between the core's requesters (instruction fetch, load/store, optional extra ports) and the byte-serial RAM/UART bus.
- Accepts whole-access requests of 1, 2 or 4 bytes per channel and serialises them into byte accesses.
- Arbitrates round-robin, assembles and disassembles little-endian data, and stalls UART writes while the output buffer is full.
- Successor to the fixed two-client arbitration inside the load/store buffer; generalised in channel count and access width, and adds flush.

Parameters:
- NUM_CH, 2, number of requester channels (1..8); channel 0 is instruction fetch by convention.
- ADDR_W, 32, request and bus address width.
- IO_HI, 2'b11, value of addr[17:16] that selects UART/IO space.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global ready; low freezes the block.
- flush_in  in  1  pipeline flush (branch mispredict).
- req_valid  in  NUM_CH  per-channel request; held until resp_done for that channel.
- req_wr  in  NUM_CH  1 = write.
- req_size  in  2*NUM_CH  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_addr  in  ADDR_W*NUM_CH  byte address.
- req_wdata  in  32*NUM_CH  write data, LSB-aligned.
- resp_done  out  NUM_CH  one-cycle completion pulse, one-hot.
- resp_rdata  out  32  read data, zero-extended; valid while resp_done is high.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (asynchronous): state IDLE, rr pointer 0, resp_done 0, resp_rdata 0, mem_a 0, mem_dout 0, mem_wr 0.
- FSM states: IDLE, RD, WR, IO_WAIT.
- IDLE: on an edge with rdy_in high and any req_valid high, grant the first valid channel at or after the rr pointer.
  - Latch addr, size and data; B = 1, 2 or 4 bytes.
  - Go to WR or RD and drive byte 0 (mem_a = addr) from the same edge.
  - rr pointer becomes granted+1 mod NUM_CH.
- Writes:
  - Byte i is presented on edge E0+i with mem_a = addr+i and mem_dout = wdata[8i+7:8i].
  - On edge E0+B: mem_wr = 0, resp_done is set, return to IDLE.
- IO writes:
  - If addr[17:16] == IO_HI and io_buffer_full is high at grant, enter IO_WAIT instead of WR, with mem_wr = 0.
  - IO_WAIT goes to WR on the first edge where io_buffer_full is low.
- Reads:
  - Issue address addr+i on edge E0+i.
  - mem_din is captured one cycle later into byte lane i.
  - resp_done is set on edge E0+B+1 with all bytes assembled; upper bytes are 0.
- Back-to-back: IDLE is always re-entered for one edge, so the minimum spacing between grants is B+1 cycles for writes and B+2 for reads.
- mem_wr is gated combinationally with rdy_in, so no write byte is ever duplicated across a pause.
- rdy_in low: all state is frozen.
  - On resume, a read re-issues its oldest uncaptured byte address before continuing.
  - A write resumes with the byte that was not yet written.
- flush_in (rdy_in high):
  - A read in RD is aborted: no resp_done, return to IDLE next edge.
  - Writes and IO_WAIT complete normally.
  - A flush in IDLE blocks new grants on that edge.
- Simultaneous flush and resp_done edge on a read: resp_done is suppressed.
- An address crossing 0x1FFFF is not checked; the address simply increments.
- An illegal size is treated as word.

Optional Feature:
- MEM_ARBITER_FIXED_PRIO_EN defined: fixed priority, lowest channel index wins, rr pointer unused.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arbiter_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - IO_ADDR_UART = 0x30000 and IO_ADDR_CLK = 0x30004;
  - function size_to_bytes.
- One sub-module, rr_picker: NUM_CH-wide one-hot round-robin/fixed grant from a request vector and pointer.

Test Plan:
- Channel 1 word write 0xDEADBEEF to 0x100 -> bytes EF, BE, AD, DE at 0x100–0x103 on 4 consecutive cycles with mem_wr high, then resp_done[1] one cycle later.
- RAM preloaded 0x11,0x22,0x33,0x44 at 0x200; channel 0 word read -> resp_rdata = 0x44332211 with resp_done[0] on edge E0+5; half read -> 0x00002211.
- Both channels request continuously -> grants alternate 0,1,0,1; with MEM_ARBITER_FIXED_PRIO_EN, channel 0 only.
- Byte write 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays low throughout, then a single write of 0x41 after the buffer clears.
- flush_in asserted during the third byte of a word read -> no resp_done, IDLE next edge; a pending channel 1 request is granted the edge after.
- rdy_in dropped for 2 cycles mid-read -> same resp_rdata as the unpaused read, with latency extended by 2+1 cycles.
